// File: rtl/xy_route_pkg.sv
// Shared types and helpers for the XY-routing congestion estimator.
// Covers the FSM encoding, link-index maps, the unplaced marker and saturating counters.
package xy_route_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR,
    S_RD_E,
    S_W_E,
    S_W_A,
    S_W_B,
    S_CHK,
    S_WALK_X,
    S_WALK_Y,
    S_FIN
  } state_t;

  localparam int UNPLACED = -1;

  // X-link (x,y)-(x+1,y); x is the lower of the two columns.
  function automatic int x_link_idx(input int x, input int y, input int n);
    return x * n + y;
  endfunction

  // Y-link (x,y)-(x,y+1); y is the lower of the two rows.
  function automatic int y_link_idx(input int x, input int y, input int n);
    return x * (n - 1) + y;
  endfunction

  function automatic logic coord_ok(input int c, input int n);
    return (c != UNPLACED) && (c >= 0) && (c < n);
  endfunction

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [32:0] lim;
    lim = (33'd1 << w) - 33'd1;
    if ({1'b0, v} >= lim) return v;
    return v + 32'd1;
  endfunction

endpackage

// File: rtl/link_load_array.sv
// Per-link usage counters with a synchronous clear port and a saturating increment port.
// The post-increment value is presented combinationally so the caller can track the peak.
module link_load_array
  import xy_route_pkg::*;
#(
  parameter int DEPTH  = 56,
  parameter int LOAD_W = 16,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              clr_en,
  input  logic [IDX_W-1:0]  clr_idx,
  input  logic              inc_en,
  input  logic [IDX_W-1:0]  inc_idx,
  output logic [LOAD_W-1:0] inc_value
);

  logic [LOAD_W-1:0] load_mem [DEPTH];

  always_comb begin
    inc_value = LOAD_W'(sat_inc(32'(load_mem[inc_idx]), LOAD_W));
  end

  always_ff @(posedge clk) begin
    if (clr_en) begin
      load_mem[clr_idx] <= '0;
    end else if (inc_en) begin
      load_mem[inc_idx] <= inc_value;
    end
  end

endmodule

// File: rtl/xy_route_congestion.sv
// Routes every edge X-then-Y on the N x N grid and accumulates link usage,
// reporting total hops, peak link load, its first link and the skipped-edge count.
module xy_route_congestion
  import xy_route_pkg::*;
#(
  parameter int N      = 8,
  parameter int N_EDGE = 71,
  parameter int ADDR_W = 32,
  parameter int LOAD_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              edge_re,
  output logic [ADDR_W-1:0] edge_addr,
  input  logic [ADDR_W-1:0] ea_data,
  input  logic [ADDR_W-1:0] eb_data,
  output logic              pos_re,
  output logic [ADDR_W-1:0] pos_addr,
  input  logic [ADDR_W-1:0] posx_data,
  input  logic [ADDR_W-1:0] posy_data,
  output logic [31:0]       total_hops,
  output logic [LOAD_W-1:0] max_load,
  output logic [ADDR_W-1:0] max_link_id,
  output logic [15:0]       err_count
);

  localparam int LINKS = N * (N - 1);
  localparam int IDX_W = (LINKS > 1) ? $clog2(LINKS) : 1;
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(N * N - 1);
  localparam logic [ADDR_W-1:0] EDGE_END = ADDR_W'(N_EDGE);
  localparam logic [ADDR_W-1:0] LINKS_A  = ADDR_W'(LINKS);
  localparam logic signed [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t state_reg, state_next;

  logic [ADDR_W-1:0]        idx_reg;
  logic [ADDR_W-1:0]        dst_reg;
  logic [ADDR_W-1:0]        edge_addr_reg, pos_addr_reg;
  logic signed [ADDR_W-1:0] xa_reg, ya_reg, xb_reg, yb_reg;
  logic signed [ADDR_W-1:0] cur_x_reg, cur_y_reg;
  logic                     busy_reg, done_reg;
  logic [31:0]              total_hops_reg;
  logic [LOAD_W-1:0]        max_load_reg;
  logic [ADDR_W-1:0]        max_link_reg;
  logic [15:0]              err_reg;

  logic                     x_dn, y_dn;
  logic signed [ADDR_W-1:0] new_x, new_y;
  int                       x_idx_int, y_idx_int;
  logic                     coords_ok;
  logic                     edge_finished;
  logic                     clr_en, x_inc_en, y_inc_en;
  logic [IDX_W-1:0]         clr_idx, x_inc_idx, y_inc_idx;
  logic [LOAD_W-1:0]        x_inc_value, y_inc_value;

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign total_hops  = total_hops_reg;
  assign max_load    = max_load_reg;
  assign max_link_id = max_link_reg;
  assign err_count   = err_reg;

  // One step of the walk: the link crossed is indexed by the lower coordinate.
  always_comb begin
    x_dn      = xb_reg < cur_x_reg;
    new_x     = x_dn ? cur_x_reg - ONE : cur_x_reg + ONE;
    x_idx_int = x_link_idx(int'(x_dn ? new_x : cur_x_reg), int'(cur_y_reg), N);
    y_dn      = yb_reg < cur_y_reg;
    new_y     = y_dn ? cur_y_reg - ONE : cur_y_reg + ONE;
    y_idx_int = y_link_idx(int'(cur_x_reg), int'(y_dn ? new_y : cur_y_reg), N);
    coords_ok = coord_ok(int'(xa_reg), N) && coord_ok(int'(ya_reg), N) &&
                coord_ok(int'(xb_reg), N) && coord_ok(int'(yb_reg), N);
  end

  assign x_inc_idx = x_idx_int[IDX_W-1:0];
  assign y_inc_idx = y_idx_int[IDX_W-1:0];
  assign clr_idx   = idx_reg[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // Walk states look ahead so every walk cycle is exactly one hop.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (start) state_next = S_CLR;
      S_CLR:    if (idx_reg == CLR_LAST) state_next = S_RD_E;
      S_RD_E:   state_next = (idx_reg == EDGE_END) ? S_FIN : S_W_E;
      S_W_E:    state_next = S_W_A;
      S_W_A:    state_next = S_W_B;
      S_W_B:    state_next = S_CHK;
      S_CHK: begin
        if (!coords_ok)            state_next = S_RD_E;
        else if (xa_reg != xb_reg) state_next = S_WALK_X;
        else if (ya_reg != yb_reg) state_next = S_WALK_Y;
        else                       state_next = S_RD_E;
      end
      S_WALK_X: if (new_x == xb_reg) state_next = (cur_y_reg != yb_reg) ? S_WALK_Y : S_RD_E;
      S_WALK_Y: if (new_y == yb_reg) state_next = S_RD_E;
      S_FIN:    state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    edge_re   = (state_reg == S_RD_E) && (idx_reg != EDGE_END);
    edge_addr = edge_re ? idx_reg : edge_addr_reg;
    pos_re    = (state_reg == S_W_E) || (state_reg == S_W_A);
    pos_addr  = pos_addr_reg;
    if (state_reg == S_W_E)      pos_addr = ea_data;
    else if (state_reg == S_W_A) pos_addr = dst_reg;
    clr_en    = (state_reg == S_CLR) && (idx_reg < LINKS_A);
    x_inc_en  = (state_reg == S_WALK_X);
    y_inc_en  = (state_reg == S_WALK_Y);
    edge_finished = (state_next == S_RD_E) &&
                    ((state_reg == S_CHK) || (state_reg == S_WALK_X) || (state_reg == S_WALK_Y));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_reg        <= '0;
      dst_reg        <= '0;
      edge_addr_reg  <= '0;
      pos_addr_reg   <= '0;
      xa_reg         <= '0;
      ya_reg         <= '0;
      xb_reg         <= '0;
      yb_reg         <= '0;
      cur_x_reg      <= '0;
      cur_y_reg      <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      total_hops_reg <= '0;
      max_load_reg   <= '0;
      max_link_reg   <= '0;
      err_reg        <= '0;
    end else begin
      edge_addr_reg <= edge_addr;
      pos_addr_reg  <= pos_addr;
      case (state_reg)
        S_IDLE: if (start) begin
          busy_reg       <= 1'b1;
          done_reg       <= 1'b0;
          total_hops_reg <= '0;
          max_load_reg   <= '0;
          max_link_reg   <= '0;
          err_reg        <= '0;
          idx_reg        <= '0;
        end
        S_CLR: idx_reg <= (idx_reg == CLR_LAST) ? '0 : idx_reg + 1'b1;
        S_W_E: dst_reg <= eb_data;
        S_W_A: begin
          xa_reg <= posx_data;
          ya_reg <= posy_data;
        end
        S_W_B: begin
          xb_reg <= posx_data;
          yb_reg <= posy_data;
        end
        S_CHK: begin
          if (!coords_ok) err_reg <= 16'(sat_inc(32'(err_reg), 16));
          cur_x_reg <= xa_reg;
          cur_y_reg <= ya_reg;
        end
        S_WALK_X: begin
          cur_x_reg      <= new_x;
          total_hops_reg <= total_hops_reg + 32'd1;
          if (x_inc_value > max_load_reg) begin
            max_load_reg <= x_inc_value;
            max_link_reg <= ADDR_W'(x_idx_int);
          end
        end
        S_WALK_Y: begin
          cur_y_reg      <= new_y;
          total_hops_reg <= total_hops_reg + 32'd1;
          if (y_inc_value > max_load_reg) begin
            max_load_reg <= y_inc_value;
            max_link_reg <= ADDR_W'(LINKS + y_idx_int);
          end
        end
        S_FIN: begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end
        default: ;
      endcase
      if (edge_finished) idx_reg <= idx_reg + 1'b1;
    end
  end

  link_load_array #(.DEPTH(LINKS), .LOAD_W(LOAD_W), .IDX_W(IDX_W)) u_x_links (
    .clk       (clk),
    .clr_en    (clr_en),
    .clr_idx   (clr_idx),
    .inc_en    (x_inc_en),
    .inc_idx   (x_inc_idx),
    .inc_value (x_inc_value)
  );

  link_load_array #(.DEPTH(LINKS), .LOAD_W(LOAD_W), .IDX_W(IDX_W)) u_y_links (
    .clk       (clk),
    .clr_en    (clr_en),
    .clr_idx   (clr_idx),
    .inc_en    (y_inc_en),
    .inc_idx   (y_inc_idx),
    .inc_value (y_inc_value)
  );

endmodule

// File: tb/tb_xy_route_congestion.sv
// Directed bench for xy_route_congestion on a 4x4 grid with four-edge ROMs and 2-bit link counters.
// Unused edge slots are zero-length self edges, which cost 5 cycles and add nothing.
module tb_xy_route_congestion;

  localparam int N      = 4;
  localparam int N_EDGE = 4;
  localparam int ADDR_W = 32;
  localparam int LOAD_W = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              busy, done, edge_re, pos_re;
  logic [ADDR_W-1:0] edge_addr, pos_addr, max_link_id;
  logic [ADDR_W-1:0] ea_data = '0, eb_data = '0, posx_data = '0, posy_data = '0;
  logic [31:0]       total_hops;
  logic [LOAD_W-1:0] max_load;
  logic [15:0]       err_count;

  xy_route_congestion #(.N(N), .N_EDGE(N_EDGE), .ADDR_W(ADDR_W), .LOAD_W(LOAD_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .edge_re     (edge_re),
    .edge_addr   (edge_addr),
    .ea_data     (ea_data),
    .eb_data     (eb_data),
    .pos_re      (pos_re),
    .pos_addr    (pos_addr),
    .posx_data   (posx_data),
    .posy_data   (posy_data),
    .total_hops  (total_hops),
    .max_load    (max_load),
    .max_link_id (max_link_id),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  // Nodes: 0(0,0) 1(2,3) 2(0,2) 3(unplaced,1) 4(3,3) 5(1,1) 6(1,0) 7(1,3)
  int ea_mem [N_EDGE];
  int eb_mem [N_EDGE];
  int px_mem [8] = '{0, 2, 0, -1, 3, 1, 1, 1};
  int py_mem [8] = '{0, 3, 2,  1, 3, 1, 0, 3};

  always @(posedge clk) begin
    if (edge_re) begin
      ea_data <= ea_mem[edge_addr[1:0]];
      eb_data <= eb_mem[edge_addr[1:0]];
    end
    if (pos_re) begin
      posx_data <= px_mem[pos_addr[2:0]];
      posy_data <= py_mem[pos_addr[2:0]];
    end
  end

  typedef struct {
    int hops;
    int load;
    int link;
    int err;
    int cyc;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic set_edges(input int a0, input int b0, input int a1, input int b1,
                           input int a2, input int b2, input int a3, input int b3);
    ea_mem[0] = a0; eb_mem[0] = b0;
    ea_mem[1] = a1; eb_mem[1] = b1;
    ea_mem[2] = a2; eb_mem[2] = b2;
    ea_mem[3] = a3; eb_mem[3] = b3;
  endtask

  // Cycle count is the number of clock edges after the accepting edge until done is seen.
  task automatic run(input string name, input int hops, input int load, input int link,
                     input int err, input int cyc, input int poke);
    exp_t e;
    int   n;
    e = '{hops, load, link, err, cyc};
    sb_q.push_back(e);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    chk({name, "_busy_on"}, 64'(busy), 64'd1);
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
      start = (n == poke);
    end
    start = 1'b0;
    e = sb_q.pop_front();
    chk({name, "_cycles"}, 64'(n), 64'(e.cyc));
    chk({name, "_hops"}, 64'(total_hops), 64'(e.hops));
    chk({name, "_max_load"}, 64'(max_load), 64'(e.load));
    chk({name, "_max_link"}, 64'(max_link_id), 64'(e.link));
    chk({name, "_err"}, 64'(err_count), 64'(e.err));
    chk({name, "_busy_off"}, 64'(busy), 64'd0);
    $display("run %s: cycles=%0d hops=%0d max_load=%0d max_link=%0d err=%0d",
             name, n, total_hops, max_load, max_link_id, err_count);
  endtask

  initial begin
    set_edges(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_edge_re", 64'(edge_re), 64'd0);
    chk("rst_pos_re", 64'(pos_re), 64'd0);
    chk("rst_hops", 64'(total_hops), 64'd0);
    chk("rst_max_load", 64'(max_load), 64'd0);
    chk("rst_max_link", 64'(max_link_id), 64'd0);
    chk("rst_err", 64'(err_count), 64'd0);

    // 5-hop edge: 16 clear + 10 + 3*5 + 2
    set_edges(0, 1, 0, 0, 0, 0, 0, 0);
    run("one_edge", 5, 1, 0, 0, 43, -1);

    // Two identical Y-only edges; a start pulse mid-run must be ignored.
    set_edges(0, 2, 0, 2, 0, 0, 0, 0);
    run("dup_y", 4, 2, 12, 0, 42, 5);

    // Sink of edge 1 is unplaced.
    set_edges(0, 1, 0, 3, 0, 0, 0, 0);
    run("unplaced", 5, 1, 0, 1, 43, -1);

    // (3,3)->(1,1) then (1,3)->(1,1): Y-link 1*3+2 reaches 2 first.
    set_edges(4, 5, 7, 5, 0, 0, 0, 0);
    run("reverse", 6, 2, 17, 0, 44, -1);

    // Four passes over X-link 0 with a 2-bit counter.
    set_edges(0, 6, 0, 6, 0, 6, 0, 6);
    run("saturate", 4, 3, 0, 0, 42, -1);

    // Abort mid WALK_X, then rerun from a clean start.
    set_edges(0, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (22) @(negedge clk);
    chk("abort_mid_walk_hops", 64'(total_hops), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hops", 64'(total_hops), 64'd0);
    chk("abort_max_load", 64'(max_load), 64'd0);
    chk("abort_err", 64'(err_count), 64'd0);
    chk("abort_strobes", 64'({edge_re, pos_re}), 64'd0);
    run("after_reset", 5, 1, 0, 0, 43, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
